// File: rtl/and_truth_checker.sv
// Exhaustive sweep checker for an N-input AND-type gate. It drives every
// input vector in ascending order and holds each one for SETTLE cycles. It
// then compares the gate output against the reduction-AND of the vector.
// The results are pass, a saturating error count and the first failing vector.
module and_truth_checker #(
  parameter int unsigned N      = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     stim,
  input  logic             f_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N-1:0]     first_fail_vec,
  output logic             first_fail_valid
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [N-1:0]     stim_d, ffv_d;
  logic [ERR_W-1:0] err_d;
  logic             busy_d, done_d, pass_d, ffval_d;
  logic             mismatch_c;

  assign mismatch_c = (f_in != (&stim));

  // Next-state and next-output logic; every register has a held default
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    stim_d  = stim;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    err_d   = err_cnt;
    ffv_d   = first_fail_vec;
    ffval_d = first_fail_valid;
    case (state)
      S_IDLE: begin
        if (start) begin
          stim_d  = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffv_d   = '0;
          ffval_d = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (mismatch_c) begin
          if (err_cnt != '1) err_d = err_cnt + ERR_W'(1);
          if (!first_fail_valid) begin
            ffv_d   = stim;
            ffval_d = 1'b1;
          end
        end
        if (&stim) begin
          // Last vector: report the result and leave stim at all-ones
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = !(first_fail_valid || mismatch_c);
          state_d = S_DONE;
        end else begin
          stim_d  = stim + N'(1);
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      stim             <= stim_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_cnt          <= err_d;
      first_fail_vec   <= ffv_d;
      first_fail_valid <= ffval_d;
    end
  end

endmodule

// File: tb/tb_and_truth_checker.sv
// Directed bench for and_truth_checker: correct and faulty gate models,
// error-counter saturation, ignored restarts, mid-sweep reset, back-to-back sweeps.
module tb_and_truth_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] stim, stim2;
  logic       f_in;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic [1:0] ffv, ffv2;
  logic       ffval, ffval2;
  logic       busy2, done2, pass2;
  logic [0:0] err2;
  int         mode;
  int         tests = 0;
  int         fails = 0;
  int         cyc;
  logic [1:0] stim_log [0:15];

  always #5 clk = ~clk;

  // Gate model: 0 correct AND, 1 OR fault, 2 stuck-0, 3 stuck-1
  always_comb begin
    case (mode)
      1:       f_in = stim[1] | stim[0];
      2:       f_in = 1'b0;
      3:       f_in = 1'b1;
      default: f_in = stim[1] & stim[0];
    endcase
  end

  and_truth_checker #(.N(2), .SETTLE(1), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .f_in(f_in),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vec(ffv), .first_fail_valid(ffval)
  );

  // One-bit error counter against a stuck-1 gate, for saturation
  and_truth_checker #(.N(2), .SETTLE(1), .ERR_W(1)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stim(stim2), .f_in(1'b1),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_fail_vec(ffv2), .first_fail_valid(ffval2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start, then run until done, with an optional start re-pulse at edge index repulse
  task automatic run_sweep(input int repulse, input bit chk_accept, output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (chk_accept) begin
      check("accept_err", 32'(err_cnt), 32'd0);
      check("accept_ffval", 32'(ffval), 32'd0);
      check("accept_pass", 32'(pass), 32'd0);
      check("accept_busy", 32'(busy), 32'd1);
      check("accept_stim", 32'(stim), 32'd0);
    end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      start = (n == repulse) ? 1'b1 : 1'b0;
      tick();
      n++;
      if (n < 16) stim_log[n] = stim;
    end
    start = 1'b0;
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_walk [1:8];
    int dcount;
    exp_walk = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; start = 1'b0; mode = 0;
    tick(); tick();
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_ffval", 32'(ffval), 32'd0);
    rst = 1'b0;
    tick();

    // Correct gate: full ascending walk, pass
    mode = 0;
    run_sweep(-1, 1'b1, cyc);
    check("clean_latency", 32'(cyc), 32'd8);
    for (int i = 1; i <= 8; i++) check($sformatf("walk_%0d", i), 32'(stim_log[i]), 32'(exp_walk[i]));
    check("clean_busy", 32'(busy), 32'd0);
    check("clean_pass", 32'(pass), 32'd1);
    check("clean_err", 32'(err_cnt), 32'd0);
    check("clean_ffval", 32'(ffval), 32'd0);
    check("sat_err", 32'(err2), 32'd1);
    check("sat_pass", 32'(pass2), 32'd0);
    check("sat_ffv", 32'(ffv2), 32'd0);
    check("sat_done", 32'(done2), 32'd1);
    tick();
    check("done_pulse_low", 32'(done), 32'd0);
    check("idle_stim_held", 32'(stim), 32'd3);
    check("idle_pass_held", 32'(pass), 32'd1);

    // OR fault: mismatches at 01 and 10
    mode = 1;
    run_sweep(-1, 1'b0, cyc);
    check("or_err", 32'(err_cnt), 32'd2);
    check("or_ffv", 32'(ffv), 32'd1);
    check("or_ffval", 32'(ffval), 32'd1);
    check("or_pass", 32'(pass), 32'd0);
    tick(); tick();
    check("or_err_held", 32'(err_cnt), 32'd2);

    // Back-to-back with correct gate: results cleared at accept
    mode = 0;
    run_sweep(-1, 1'b1, cyc);
    check("b2b_pass", 32'(pass), 32'd1);
    check("b2b_err", 32'(err_cnt), 32'd0);
    tick();

    // Stuck-0: only 11 fails
    mode = 2;
    run_sweep(-1, 1'b0, cyc);
    check("s0_err", 32'(err_cnt), 32'd1);
    check("s0_ffv", 32'(ffv), 32'd3);
    check("s0_pass", 32'(pass), 32'd0);
    tick();

    // Stuck-1: 00, 01, 10 fail
    mode = 3;
    run_sweep(-1, 1'b0, cyc);
    check("s1_err", 32'(err_cnt), 32'd3);
    check("s1_ffv", 32'(ffv), 32'd0);
    check("s1_pass", 32'(pass), 32'd0);
    tick();

    // Start re-pulsed during SETTLE is ignored
    mode = 0;
    run_sweep(2, 1'b0, cyc);
    check("repulse_latency", 32'(cyc), 32'd8);
    check("repulse_pass", 32'(pass), 32'd1);
    tick(); tick(); tick();
    check("repulse_no_restart", 32'(busy), 32'd0);

    // Reset mid-sweep at stim=10
    mode = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && stim != 2'd2; i++) tick();
    check("reached_10", 32'(stim), 32'd2);
    rst = 1'b1;
    tick();
    check("mid_rst_stim", 32'(stim), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err_cnt), 32'd0);
    check("mid_rst_ffv", 32'(ffv), 32'd0);
    check("mid_rst_ffval", 32'(ffval), 32'd0);
    check("mid_rst_pass", 32'(pass), 32'd0);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcount++;
    end
    check("mid_rst_no_done", 32'(dcount), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/and_truth_checker.md
Name: and_truth_checker

Overview:
- Self-checking sweep engine: the receiving end of the AND-gate stimulus interface.
- Drives every input vector of an N-input AND-type DUT in ascending order, waits a settle interval, samples the DUT output and compares it with the expected reduction-AND.
- Reports pass/fail, a saturating error count and the first failing vector.
- Sits beside the gate under test as an on-chip BIST/sign-off checker, replacing the free-running stimulus counter.

Parameters:
N, 2, number of DUT inputs; sweep covers 2^N vectors (N >= 1).
SETTLE, 1, cycles each vector is held before sampling (SETTLE >= 1).
ERR_W, 8, width of error counter (saturating).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  begin sweep; sampled only in IDLE.
stim  output  N  vector driven to DUT inputs.
f_in  input  1  DUT output under test.
busy  output  1  high while a sweep is in progress.
done  output  1  one-cycle pulse when the sweep completes.
pass  output  1  sweep result, held until the next accepted start.
err_cnt  output  ERR_W  number of mismatching vectors, saturating at all-ones.
first_fail_vec  output  N  stim value of the first mismatch.
first_fail_valid  output  1  first_fail_vec holds a captured mismatch.

Behaviour:
- Reset values (next clk edge with rst=1, any state): state=IDLE, stim=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0, settle counter=0.
- States: IDLE, SETTLE, CHECK, DONE. busy=1 in SETTLE and CHECK.
- IDLE, start=1: stim<=0, cnt<=0, err_cnt<=0, first_fail_valid<=0, first_fail_vec<=0, pass<=0; go to SETTLE. start=0: remain in IDLE, outputs held.
- SETTLE: cnt increments each cycle; at cnt==SETTLE-1 go to CHECK. stim is stable for exactly SETTLE cycles before CHECK.
- CHECK: expected = &stim. Mismatch occurs when f_in != expected, with f_in sampled at the CHECK edge.
  - On mismatch, err_cnt increments unless it is already all-ones.
  - On the first mismatch (first_fail_valid=0), capture first_fail_vec<=stim and set first_fail_valid<=1.
  - If stim is all-ones, go to DONE. Otherwise stim<=stim+1, cnt<=0, go to SETTLE.
- DONE, one cycle: done=1, pass=(no mismatch during the sweep), busy=0, stim holds all-ones; then go to IDLE. done is low in every other state.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - The done pulse appears 2^N*(SETTLE+1) cycles after the start-accept edge.
  - For N=2, SETTLE=1, done rises 8 cycles after start is accepted.
- start is ignored while busy or in DONE; a new sweep requires start in IDLE.
- err_cnt, pass, first_fail_* persist after done until the next accepted start or rst.
- No wrap-around of stim: the sweep ends at all-ones, with no increment past it.
- Reset has priority over every state transition, including the CHECK cycle and the DONE pulse.

Test Plan:
- N=2, SETTLE=1, f_in = stim[1]&stim[0], pulse start -> stim walks 00,01,10,11 (2 cycles each); done pulses once 8 cycles after start; pass=1, err_cnt=0, first_fail_valid=0.
- f_in = stim[1]|stim[0] (OR fault) -> err_cnt=2, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
- f_in stuck 0 -> err_cnt=1, first_fail_vec=2'b11, pass=0; f_in stuck 1 -> err_cnt=3, first_fail_vec=2'b00.
- ERR_W=1, f_in stuck 1 -> err_cnt saturates at 1 (no wrap to 0); pass=0.
- Sweep running, start re-pulsed in SETTLE -> ignored, done still at cycle 8. Then rst asserted at stim=2'b10 -> next edge all outputs at reset values, no done pulse.
- Back-to-back sweeps: OR-fault sweep, then correct model with a new start -> err_cnt and first_fail_valid cleared at accept; second sweep gives pass=1.
